// File: rtl/seg7_capture_if.sv
// Bus bundle for seg7_capture: scanned active-low segment input side plus decoded results.
// err_count is present only when SEG7CAP_ERRCNT_EN is defined.
interface seg7_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   dig_en;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic                    update;
  logic [2:0]              update_idx;
  logic                    err;
`ifdef SEG7CAP_ERRCNT_EN
  logic [7:0]              err_count;
`endif

  modport master (
    output seg_in, dig_en,
`ifdef SEG7CAP_ERRCNT_EN
    input  err_count,
`endif
    input  value, digit_valid, update, update_idx, err
  );

  modport slave (
    input  seg_in, dig_en,
`ifdef SEG7CAP_ERRCNT_EN
    output err_count,
`endif
    output value, digit_valid, update, update_idx, err
  );
endinterface

// File: rtl/seg7_capture.sv
// Decodes a scanned active-low 7-segment bus back into per-digit hex nibbles once a pattern is stable.
// Optional saturating error counter is enabled with SEG7CAP_ERRCNT_EN.
module seg7_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic           clk,
  input logic           rst_n,
  seg7_capture_if.slave bus
);

  localparam logic [7:0] CNT_TC  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);

  logic [6:0]                  samp_seg;
  logic [NUM_DIGITS-1:0]       samp_en;
  logic [7:0]                  cnt;
  logic [NUM_DIGITS-1:0][3:0]  value_q;
  logic [NUM_DIGITS-1:0]       valid_q;
  logic                        update_q;
  logic [2:0]                  update_idx_q;
  logic                        err_q;

  logic       same;
  logic       fire;
  logic       dec_legal;
  logic       dec_blank;
  logic [3:0] dec_nib;
  logic [2:0] hot_idx;
  logic       write_set;
  logic       blank_set;
  logic       err_set;

  assign same = (bus.seg_in == samp_seg) && (bus.dig_en == samp_en);
  assign fire = same && (cnt == CNT_TC);

  always_comb begin
    dec_legal = 1'b1;
    dec_blank = 1'b0;
    dec_nib   = 4'h0;
    case (samp_seg)
      7'h01: dec_nib = 4'h0;
      7'h4F: dec_nib = 4'h1;
      7'h12: dec_nib = 4'h2;
      7'h06: dec_nib = 4'h3;
      7'h4C: dec_nib = 4'h4;
      7'h24: dec_nib = 4'h5;
      7'h20: dec_nib = 4'h6;
      7'h0F: dec_nib = 4'h7;
      7'h00: dec_nib = 4'h8;
      7'h0C: dec_nib = 4'h9;
      7'h08: dec_nib = 4'hA;
      7'h60: dec_nib = 4'hB;
      7'h31: dec_nib = 4'hC;
      7'h42: dec_nib = 4'hD;
      7'h30: dec_nib = 4'hE;
      7'h38: dec_nib = 4'hF;
      7'h7F: begin
        dec_legal = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    hot_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (samp_en[i]) hot_idx = 3'(i);
    end
  end

  // All-zero select is inter-digit blanking and commits nothing.
  always_comb begin
    write_set = 1'b0;
    blank_set = 1'b0;
    err_set   = 1'b0;
    if (fire && (samp_en != '0)) begin
      if (!$onehot(samp_en)) err_set   = 1'b1;
      else if (dec_legal)    write_set = 1'b1;
      else if (dec_blank)    blank_set = 1'b1;
      else                   err_set   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_seg     <= 7'h7F;
      samp_en      <= '0;
      cnt          <= 8'd0;
      value_q      <= '0;
      valid_q      <= '0;
      update_q     <= 1'b0;
      update_idx_q <= 3'd0;
      err_q        <= 1'b0;
    end else begin
      if (!same) begin
        samp_seg <= bus.seg_in;
        samp_en  <= bus.dig_en;
        cnt      <= 8'd0;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + 8'd1;
      end

      update_q <= write_set || blank_set;
      err_q    <= err_set;
      if (write_set || blank_set) update_idx_q <= hot_idx;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (samp_en[i] && write_set) begin
          value_q[i] <= dec_nib;
          valid_q[i] <= 1'b1;
        end else if (samp_en[i] && blank_set) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SEG7CAP_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_cnt_q <= 8'd0;
    else if (err_set && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign bus.err_count = err_cnt_q;
`endif

  assign bus.value       = value_q;
  assign bus.digit_valid = valid_q;
  assign bus.update      = update_q;
  assign bus.update_idx  = update_idx_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: vector table for decode/commit plus hand sequences
// for glitch rejection, long hold and reset in the middle of a count.
module tb_seg7_capture;
  localparam int ND = 4;
  localparam int S  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   exp_errs;

  seg7_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = no action, 1 = write, 2 = blank, 3 = error
  typedef struct {
    logic [3:0] en;
    logic [6:0] seg;
    int         kind;
    logic [2:0] idx;
    logic [3:0] nib;
  } vec_t;

  vec_t       vecs[22];
  logic [6:0] enc[16];
  logic [15:0] m_value;
  logic [3:0]  m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] seg);
    bus.dig_en = en;
    bus.seg_in = seg;
  endtask

  // Drive and wait S edges, returning how many pulses appeared before the commit edge.
  task automatic hold_pre(input logic [3:0] en, input logic [6:0] seg, output int early);
    early = 0;
    drive(en, seg);
    for (int c = 0; c < S; c++) begin
      @(posedge clk); #1;
      if (bus.update || bus.err) early++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_value"}, 32'(bus.value), 32'(m_value));
    chk({tag, "_valid"}, 32'(bus.digit_valid), 32'(m_valid));
  endtask

  initial begin
    int early;
    int pulses;
    checks = 0;
    errors = 0;
    exp_errs = 0;
    m_value = '0;
    m_valid = '0;

    enc = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
            7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    for (int i = 0; i < 16; i++)
      vecs[i] = '{en: 4'b0001 << (i % 4), seg: enc[i], kind: 1, idx: 3'(i % 4), nib: 4'(i)};
    vecs[16] = '{en: 4'b1000, seg: 7'h7F, kind: 2, idx: 3'd3, nib: 4'h0};
    vecs[17] = '{en: 4'b0100, seg: 7'h55, kind: 3, idx: 3'd0, nib: 4'h0};
    vecs[18] = '{en: 4'b0011, seg: 7'h01, kind: 3, idx: 3'd0, nib: 4'h0};
    vecs[19] = '{en: 4'b0000, seg: 7'h01, kind: 0, idx: 3'd0, nib: 4'h0};
    vecs[20] = '{en: 4'b0100, seg: 7'h12, kind: 1, idx: 3'd2, nib: 4'h2};
    vecs[21] = '{en: 4'b1000, seg: 7'h38, kind: 1, idx: 3'd3, nib: 4'hF};

    // Reset with random inputs
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(4'($urandom), 7'($urandom));
      @(posedge clk); #1;
    end
    chk("rst_value", 32'(bus.value), 32'h0);
    chk("rst_valid", 32'(bus.digit_valid), 32'h0);
    chk("rst_pulses", {29'd0, bus.update, bus.err, 1'b0} | 32'(bus.update_idx), 32'h0);
`ifdef SEG7CAP_ERRCNT_EN
    chk("rst_errcnt", 32'(bus.err_count), 32'h0);
`endif
    drive(4'b0000, 7'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (bus.update || bus.err) pulses++;
    end
    chk("post_rst_quiet", 32'(pulses), 32'h0);

    // Table: all 16 codes across the digits, blank, illegal pattern/select, no-select
    for (int v = 0; v < 22; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      hold_pre(vecs[v].en, vecs[v].seg, early);
      chk({tag, "_early"}, 32'(early), 32'h0);
      @(posedge clk); #1;
      chk({tag, "_update"}, 32'(bus.update), 32'(vecs[v].kind == 1 || vecs[v].kind == 2));
      chk({tag, "_err"}, 32'(bus.err), 32'(vecs[v].kind == 3));
      if (vecs[v].kind == 1 || vecs[v].kind == 2)
        chk({tag, "_idx"}, 32'(bus.update_idx), 32'(vecs[v].idx));
      case (vecs[v].kind)
        1: begin
          m_value[4*vecs[v].idx +: 4] = vecs[v].nib;
          m_valid[vecs[v].idx] = 1'b1;
        end
        2: m_valid[vecs[v].idx] = 1'b0;
        3: exp_errs++;
        default: ;
      endcase
      check_model(tag);
      @(posedge clk); #1;
      chk({tag, "_pulse_width"}, {30'd0, bus.update, bus.err}, 32'h0);
    end

    // Single digit then a long hold: exactly one commit
    hold_pre(4'b0010, 7'h24, early);
    chk("single_early", 32'(early), 32'h0);
    @(posedge clk); #1;
    chk("single_update", 32'(bus.update), 32'h1);
    chk("single_idx", 32'(bus.update_idx), 32'h1);
    m_value[7:4] = 4'h5;
    m_valid[1] = 1'b1;
    check_model("single");
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.update || bus.err) pulses++;
    end
    chk("hold_no_repeat", 32'(pulses), 32'h0);

    // Glitch: 3-sample pattern is rejected, the following stable one commits
    drive(4'b0001, 7'h06);
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.update || bus.err) pulses++;
    end
    hold_pre(4'b0001, 7'h4F, early);
    chk("glitch_early", 32'(pulses + early), 32'h0);
    @(posedge clk); #1;
    chk("glitch_update", 32'(bus.update), 32'h1);
    chk("glitch_nib0", 32'(bus.value[3:0]), 32'h1);

`ifdef SEG7CAP_ERRCNT_EN
    chk("errcnt", 32'(bus.err_count), 32'(exp_errs));
`endif

    // Reset in the middle of a count, then a clean restart
    drive(4'b0100, 7'h4C);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_value", 32'(bus.value), 32'h0);
    chk("midrst_valid", 32'(bus.digit_valid), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < S; c++) begin
      @(posedge clk); #1;
      if (bus.update || bus.err) pulses++;
    end
    chk("midrst_early", 32'(pulses), 32'h0);
    @(posedge clk); #1;
    chk("midrst_update", 32'(bus.update), 32'h1);
    chk("midrst_idx", 32'(bus.update_idx), 32'h2);
    chk("midrst_nib2", 32'(bus.value), 32'h0400);
    chk("midrst_valid2", 32'(bus.digit_valid), 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
